// File: rtl/init_done_sequencer_if.sv
// Init-done sequencer bus: raw init-done flags and mask in, sequenced resets and status out.
interface init_done_sequencer_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] INIT_DONE_IN;
  logic [NUM_CH-1:0] REQUIRED_MASK;
  logic [NUM_CH-1:0] CH_RESETN;
  logic              ALL_DONE;
  logic              DROP_ERR;
  logic              TIMEOUT;
  logic [NUM_CH-1:0] TIMEOUT_MISSING;

  modport master (
    output INIT_DONE_IN, REQUIRED_MASK,
    input  CH_RESETN, ALL_DONE, DROP_ERR, TIMEOUT, TIMEOUT_MISSING
  );

  modport slave (
    input  INIT_DONE_IN, REQUIRED_MASK,
    output CH_RESETN, ALL_DONE, DROP_ERR, TIMEOUT, TIMEOUT_MISSING
  );
endinterface

// File: rtl/init_done_sequencer.sv
// Synchronises init-done flags, qualifies them and releases per-channel resets in staggered order.
// Optional startup timeout monitor is enabled with `define INIT_SEQ_TIMEOUT_EN.
module init_done_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 16,
  parameter int RELEASE_GAP    = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  init_done_sequencer_if.slave  bus
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int GW = $clog2(RELEASE_GAP + 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(RELEASE_GAP - 1);

  typedef enum logic [1:0] {
    ST_QUAL,
    ST_RELEASE,
    ST_GAP,
    ST_DONE
  } state_e;

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0]                  sync;
  logic                               ok;

  state_e            state_q;
  logic [SW-1:0]     stable_cnt_q;
  logic [GW-1:0]     gap_cnt_q;
  logic [NUM_CH-1:0] ch_resetn_q;
  logic              all_done_q;
  logic              drop_err_q;

  // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.INIT_DONE_IN};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign ok   = &(sync | ~bus.REQUIRED_MASK);

  // ch_resetn_q is a thermometer code: releases shift in a 1 from bit 0, so the
  // top bit being set marks the final release and no separate channel index is kept.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= ST_QUAL;
      stable_cnt_q <= '0;
      gap_cnt_q    <= '0;
      ch_resetn_q  <= '0;
      all_done_q   <= 1'b0;
      drop_err_q   <= 1'b0;
    end else if (state_q != ST_QUAL && !ok) begin
      // Drop takes priority over any release or completion in the same cycle.
      state_q      <= ST_QUAL;
      stable_cnt_q <= '0;
      gap_cnt_q    <= '0;
      ch_resetn_q  <= '0;
      all_done_q   <= 1'b0;
      drop_err_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_QUAL: begin
          if (!ok) begin
            stable_cnt_q <= '0;
          end else if (stable_cnt_q == STABLE_LAST) begin
            // Channel 0 is released on the same edge that enters RELEASE.
            state_q      <= ST_RELEASE;
            stable_cnt_q <= '0;
            ch_resetn_q  <= NUM_CH'(1);
          end else begin
            stable_cnt_q <= stable_cnt_q + SW'(1);
          end
        end
        ST_RELEASE: begin
          gap_cnt_q <= '0;
          if (ch_resetn_q[NUM_CH-1]) begin
            state_q    <= ST_DONE;
            all_done_q <= 1'b1;
          end else begin
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_q   <= '0;
            state_q     <= ST_RELEASE;
            ch_resetn_q <= (ch_resetn_q << 1) | NUM_CH'(1);
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        ST_DONE: begin
          all_done_q <= 1'b1;
        end
        default: begin
          state_q <= ST_QUAL;
        end
      endcase
    end
  end

  assign bus.CH_RESETN = ch_resetn_q;
  assign bus.ALL_DONE  = all_done_q;
  assign bus.DROP_ERR  = drop_err_q;

`ifdef INIT_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0]     tmo_cnt_q;
  logic              left_qual_q;
  logic              timeout_q;
  logic [NUM_CH-1:0] missing_q;

  // The monitor only watches the first qualification after reset; a later drop
  // back to QUAL does not restart it, and the capture happens at most once.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      tmo_cnt_q   <= '0;
      left_qual_q <= 1'b0;
      timeout_q   <= 1'b0;
      missing_q   <= '0;
    end else begin
      if (state_q != ST_QUAL) begin
        left_qual_q <= 1'b1;
      end
      if (!left_qual_q && state_q == ST_QUAL && !timeout_q) begin
        if (tmo_cnt_q == TMO_LAST) begin
          tmo_cnt_q <= TW'(TIMEOUT_CYCLES);
          timeout_q <= 1'b1;
          missing_q <= bus.REQUIRED_MASK & ~sync;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + TW'(1);
        end
      end
    end
  end

  assign bus.TIMEOUT         = timeout_q;
  assign bus.TIMEOUT_MISSING = missing_q;
`else
  assign bus.TIMEOUT         = 1'b0;
  assign bus.TIMEOUT_MISSING = '0;
`endif

endmodule

// File: tb/tb_init_done_sequencer.sv
// Directed bench for init_done_sequencer: release timeline, glitch, drop, mask, timeout, async reset.
module tb_init_done_sequencer;

  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  init_done_sequencer_if #(.NUM_CH(NCH)) bus ();

  init_done_sequencer #(
    .NUM_CH         (NCH),
    .SYNC_STAGES    (2),
    .STABLE_CYCLES  (16),
    .RELEASE_GAP    (8),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .CLK    (clk),
    .RESETN (rst_n),
    .bus    (bus)
  );

`ifdef INIT_SEQ_TIMEOUT_EN
  localparam logic       EXP_TMO     = 1'b1;
  localparam logic [3:0] EXP_MISSING = 4'b1001;
`else
  localparam logic       EXP_TMO     = 1'b0;
  localparam logic [3:0] EXP_MISSING = 4'b0000;
`endif

  // t counts edges after the inputs last changed; base is the edge of the first release.
  function automatic logic [3:0] exp_ch(int t, int base);
    logic [3:0] r = '0;
    for (int k = 0; k < NCH; k++) begin
      if (t >= base + 9 * k) r[k] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic exp_done(int t, int base);
    return t >= base + 28;
  endfunction

  task automatic apply_reset(input logic [3:0] din, input logic [3:0] mask);
    rst_n = 1'b0;
    bus.INIT_DONE_IN  = din;
    bus.REQUIRED_MASK = mask;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    bus.INIT_DONE_IN  = 4'h0;
    bus.REQUIRED_MASK = 4'hF;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.CH_RESETN, bus.ALL_DONE, bus.DROP_ERR} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ch=%b done=%b drop=%b, expected all 0",
               bus.CH_RESETN, bus.ALL_DONE, bus.DROP_ERR);
    end
    n_tests++;
    if ({bus.TIMEOUT, bus.TIMEOUT_MISSING} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_timeout: got tmo=%b miss=%b, expected 0", bus.TIMEOUT, bus.TIMEOUT_MISSING);
    end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.CH_RESETN, bus.ALL_DONE} !== 5'b0) begin
      n_fail++;
      $display("FAIL idle_low_inputs: got ch=%b done=%b, expected 0000/0", bus.CH_RESETN, bus.ALL_DONE);
    end
  endtask

  task automatic test_sequence;
    bus.INIT_DONE_IN = 4'hF;
    for (int t = 1; t <= 50; t++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.CH_RESETN !== exp_ch(t, 18) || bus.ALL_DONE !== exp_done(t, 18)) begin
        n_fail++;
        $display("FAIL sequence t=%0d: got ch=%b done=%b, expected ch=%b done=%b",
                 t, bus.CH_RESETN, bus.ALL_DONE, exp_ch(t, 18), exp_done(t, 18));
      end
    end
    n_tests++;
    if (bus.DROP_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL sequence_drop_err: got %b, expected 0", bus.DROP_ERR);
    end
  endtask

  task automatic test_drop;
    logic [3:0] ech;
    logic       edn;
    bus.INIT_DONE_IN[1] = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      @(posedge clk);
      #1;
      ech = (t >= 3) ? 4'h0 : 4'hF;
      edn = (t < 3);
      n_tests++;
      if (bus.CH_RESETN !== ech || bus.ALL_DONE !== edn || bus.DROP_ERR !== (t >= 3)) begin
        n_fail++;
        $display("FAIL drop t=%0d: got ch=%b done=%b drop=%b, expected ch=%b done=%b drop=%b",
                 t, bus.CH_RESETN, bus.ALL_DONE, bus.DROP_ERR, ech, edn, (t >= 3));
      end
    end
    bus.INIT_DONE_IN[1] = 1'b1;
    for (int t = 1; t <= 50; t++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.CH_RESETN !== exp_ch(t, 18) || bus.ALL_DONE !== exp_done(t, 18) || bus.DROP_ERR !== 1'b1) begin
        n_fail++;
        $display("FAIL drop_rerun t=%0d: got ch=%b done=%b drop=%b, expected ch=%b done=%b drop=1",
                 t, bus.CH_RESETN, bus.ALL_DONE, bus.DROP_ERR, exp_ch(t, 18), exp_done(t, 18));
      end
    end
  endtask

  task automatic test_reset_mid;
    bus.INIT_DONE_IN[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.INIT_DONE_IN[0] = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    n_tests++;
    if (bus.CH_RESETN !== 4'b0011) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got ch=%b, expected 0011", bus.CH_RESETN);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.CH_RESETN, bus.ALL_DONE, bus.DROP_ERR, bus.TIMEOUT, bus.TIMEOUT_MISSING} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got ch=%b done=%b drop=%b tmo=%b miss=%b, expected all 0",
               bus.CH_RESETN, bus.ALL_DONE, bus.DROP_ERR, bus.TIMEOUT, bus.TIMEOUT_MISSING);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int t = 1; t <= 50; t++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.CH_RESETN !== exp_ch(t, 18) || bus.ALL_DONE !== exp_done(t, 18) || bus.DROP_ERR !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_restart t=%0d: got ch=%b done=%b drop=%b, expected ch=%b done=%b drop=0",
                 t, bus.CH_RESETN, bus.ALL_DONE, bus.DROP_ERR, exp_ch(t, 18), exp_done(t, 18));
      end
    end
  endtask

  task automatic test_glitch;
    apply_reset(4'h0, 4'hF);
    bus.INIT_DONE_IN = 4'hF;
    for (int t = 1; t <= 60; t++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.CH_RESETN !== exp_ch(t, 29) || bus.ALL_DONE !== exp_done(t, 29) || bus.DROP_ERR !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch t=%0d: got ch=%b done=%b drop=%b, expected ch=%b done=%b drop=0",
                 t, bus.CH_RESETN, bus.ALL_DONE, bus.DROP_ERR, exp_ch(t, 29), exp_done(t, 29));
      end
      if (t == 10) bus.INIT_DONE_IN[2] = 1'b0;
      if (t == 11) bus.INIT_DONE_IN[2] = 1'b1;
    end
  endtask

  task automatic test_mask;
    apply_reset(4'h0, 4'b1011);
    bus.INIT_DONE_IN = 4'b1011;
    for (int t = 1; t <= 50; t++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.CH_RESETN !== exp_ch(t, 18) || bus.ALL_DONE !== exp_done(t, 18)) begin
        n_fail++;
        $display("FAIL mask t=%0d: got ch=%b done=%b, expected ch=%b done=%b",
                 t, bus.CH_RESETN, bus.ALL_DONE, exp_ch(t, 18), exp_done(t, 18));
      end
    end
  endtask

  task automatic test_timeout;
    apply_reset(4'b0110, 4'hF);
    for (int c = 1; c <= 360; c++) begin
      @(posedge clk);
      #1;
      if (c == 199) begin
        n_tests++;
        if (bus.TIMEOUT !== 1'b0) begin
          n_fail++;
          $display("FAIL timeout_early c=%0d: got tmo=%b, expected 0", c, bus.TIMEOUT);
        end
      end
      if (c == 200 || c == 360) begin
        n_tests++;
        if (bus.TIMEOUT !== EXP_TMO || bus.TIMEOUT_MISSING !== EXP_MISSING) begin
          n_fail++;
          $display("FAIL timeout c=%0d: got tmo=%b miss=%b, expected tmo=%b miss=%b",
                   c, bus.TIMEOUT, bus.TIMEOUT_MISSING, EXP_TMO, EXP_MISSING);
        end
      end
      if (c == 316 || c == 317 || c == 345 || c == 346) begin
        n_tests++;
        if (bus.CH_RESETN !== exp_ch(c - 299, 18) || bus.ALL_DONE !== exp_done(c - 299, 18)) begin
          n_fail++;
          $display("FAIL timeout_late_seq c=%0d: got ch=%b done=%b, expected ch=%b done=%b",
                   c, bus.CH_RESETN, bus.ALL_DONE, exp_ch(c - 299, 18), exp_done(c - 299, 18));
        end
      end
      if (c == 299) bus.INIT_DONE_IN = 4'hF;
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_drop();
    test_reset_mid();
    test_glitch();
    test_mask();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
